// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_pkg: shared defaults, pointer sizing and count type for the FIFO read drain.
package fifo_rd_pkg;
   localparam int DEF_WIDTH = 4;
   localparam int DEF_RD_LAT = 1;
   localparam int DEF_BUF_DEPTH = 2;
   localparam int CNT_W = 8;
   typedef logic [CNT_W-1:0] cnt_t;
   function automatic int clog2(input int n);
      int r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus downstream valid/ready stream.
interface fifo_rd_stream_if
   import fifo_rd_pkg::*;
#(parameter int Width = DEF_WIDTH);
   logic empty, ren, out_valid, out_ready;
   logic [Width-1:0] rdata, out_data;
   modport master (output empty, rdata, out_ready, input ren, out_valid, out_data);
   modport slave (input empty, rdata, out_ready, output ren, out_valid, out_data);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: circular skid buffer with registered head word, count and pointers.
module fifo_rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int Width = DEF_WIDTH,
   parameter int Depth = DEF_BUF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output cnt_t             count,
   output logic             empty
);
   localparam int PW = clog2(Depth);
   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   cnt_t count_q, count_d;
   logic full;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
   endfunction
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
      end
   end
   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full = (count_q == cnt_t'(Depth));
   // credit rule in the parent makes both of these unreachable
   assert property (@(posedge clk) disable iff (rst) !(push && !pop && full));
   assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: credit-based FIFO read drain presenting a valid/ready stream.
// Defining FIFO_RD_CNT_EN adds rd_count, a wrapping 16-bit count of delivered words.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int Width = DEF_WIDTH,
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
   input logic rclk,
   input logic r_rst,
   fifo_rd_stream_if.slave s
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [15:0] rd_count
`endif
);
   logic [RD_LAT-1:0] lat_q, lat_d;
   logic pop, push, buf_empty;
   cnt_t count, inflight;
   always_comb begin
      pop = s.out_valid && s.out_ready;
      push = lat_q[RD_LAT-1];
      inflight = cnt_t'($countones(lat_q));
      // a pop this cycle frees a slot, so the read can be reissued without a bubble
      s.ren = !r_rst && !s.empty && ((count + inflight - cnt_t'(pop)) < cnt_t'(BUF_DEPTH));
      lat_d = RD_LAT'({lat_q, s.ren});
   end
   always_ff @(posedge rclk) lat_q <= r_rst ? '0 : lat_d;
   fifo_rd_skid_buf #(.Width(Width), .Depth(BUF_DEPTH)) u_buf (
      .clk   (rclk),
      .rst   (r_rst),
      .push  (push),
      .wdata (s.rdata),
      .pop   (pop),
      .rdata (s.out_data),
      .count (count),
      .empty (buf_empty)
   );
   assign s.out_valid = !buf_empty;
`ifdef FIFO_RD_CNT_EN
   logic [15:0] rd_count_q, rd_count_d;
   always_comb rd_count_d = pop ? rd_count_q + 16'd1 : rd_count_q;
   always_ff @(posedge rclk) rd_count_q <= r_rst ? '0 : rd_count_d;
   assign rd_count = rd_count_q;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed vector table plus randomized run against a queue-based model.
module tb_fifo_rd_stream;
   import fifo_rd_pkg::*;
   localparam int W = 4, LAT = 1, DEPTH = 2;
   typedef struct {
      logic [2:0] ld;
      logic rst, rdy, ren, vld, chkd;
      logic [3:0] d;
   } vec_t;
   typedef struct {
      int due;
      logic [3:0] d;
   } pend_t;
   logic rclk = 1'b0;
   logic r_rst = 1'b1;
   fifo_rd_stream_if #(.Width(W)) bus ();
`ifdef FIFO_RD_CNT_EN
   logic [15:0] rd_count;
`endif
   fifo_rd_stream #(.Width(W), .RD_LAT(LAT), .BUF_DEPTH(DEPTH)) dut (
      .rclk  (rclk),
      .r_rst (r_rst),
      .s     (bus.slave)
`ifdef FIFO_RD_CNT_EN
      ,
      .rd_count (rd_count)
`endif
   );
   always #5 rclk = ~rclk;
   int n_cmp = 0, n_bad = 0, tick = 0;
   logic [3:0] fq[$];
   logic [3:0] mq[$];
   pend_t pq[$];
   logic [15:0] mcnt = '0;
   vec_t tbl[$];
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic add(input logic [2:0] ld, input logic rst, rdy, ren, vld, chkd, input logic [3:0] d);
      vec_t v;
      v.ld = ld; v.rst = rst; v.rdy = rdy; v.ren = ren; v.vld = vld; v.chkd = chkd; v.d = d;
      tbl.push_back(v);
   endtask
   task automatic load(input logic [2:0] k);
      case (k)
         3'd1: fq = '{4'h3, 4'h7, 4'hA, 4'hC};
         3'd2: fq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h6};
         3'd3: fq = '{4'h9, 4'hB};
         3'd4: fq = '{4'hD, 4'hE, 4'hF};
         3'd5: fq = '{4'h6, 4'h3};
         default: fq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
      endcase
   endtask
   // one rclk cycle: drive, check against the model at negedge, then advance FIFO and model
   task automatic cyc(input logic rst, input logic rdy, output logic o_ren, output logic o_vld,
                      output logic [3:0] o_d);
      logic e_vld, e_pop, e_ren;
      logic [3:0] e_d, w;
      pend_t p;
      r_rst = rst;
      bus.out_ready = rdy;
      bus.empty = (fq.size() == 0);
      e_vld = (mq.size() != 0);
      e_d = e_vld ? mq[0] : 4'h0;
      e_pop = e_vld && rdy;
      e_ren = !rst && !bus.empty && ((mq.size() + pq.size() - int'(e_pop)) < DEPTH);
      @(negedge rclk);
      o_ren = bus.ren;
      o_vld = bus.out_valid;
      o_d = bus.out_data;
      chk("model_ren", {15'd0, o_ren}, {15'd0, e_ren});
      chk("model_valid", {15'd0, o_vld}, {15'd0, e_vld});
      if (e_vld) chk("model_data", {12'd0, o_d}, {12'd0, e_d});
`ifdef FIFO_RD_CNT_EN
      chk("model_rd_count", rd_count, mcnt);
`endif
      @(posedge rclk);
      #1;
      w = (fq.size() != 0) ? fq[0] : 4'h0;
      if (o_ren && fq.size() != 0) bus.rdata = fq.pop_front();
      else bus.rdata = 4'($urandom);
      tick++;
      if (rst) begin
         mq.delete();
         pq.delete();
         mcnt = '0;
      end else begin
         if (e_pop) begin
            void'(mq.pop_front());
            mcnt++;
         end
         while (pq.size() != 0 && pq[0].due == tick) begin
            p = pq.pop_front();
            mq.push_back(p.d);
         end
         if (e_ren) begin
            p.due = tick + LAT;
            p.d = w;
            pq.push_back(p);
         end
      end
   endtask
   initial begin
      logic o_ren, o_vld, p_vld, p_rdy, p_rst;
      logic [3:0] o_d, p_d;
      bus.empty = 1'b1;
      bus.rdata = '0;
      bus.out_ready = 1'b0;
      // reset held with data available
      add(1, 1, 1, 0, 0, 1, 4'h0);
      for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0, 1, 4'h0);
      // stream 3,7,A,C
      add(0, 0, 1, 1, 0, 0, 4'h0); add(0, 0, 1, 1, 0, 0, 4'h0);
      add(0, 0, 1, 1, 1, 1, 4'h3); add(0, 0, 1, 1, 1, 1, 4'h7);
      add(0, 0, 1, 0, 1, 1, 4'hA); add(0, 0, 1, 0, 1, 1, 4'hC);
      add(0, 0, 1, 0, 0, 0, 4'h0);
      // stall six cycles, then drain without gaps
      add(2, 0, 0, 1, 0, 0, 4'h0); add(0, 0, 0, 1, 0, 0, 4'h0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, 4'h1);
      add(0, 0, 1, 1, 1, 1, 4'h1); add(0, 0, 1, 1, 1, 1, 4'h2);
      add(0, 0, 1, 1, 1, 1, 4'h4); add(0, 0, 1, 1, 1, 1, 4'h8);
      add(0, 0, 1, 0, 1, 1, 4'h5); add(0, 0, 1, 0, 1, 1, 4'h6);
      add(0, 0, 1, 0, 0, 0, 4'h0);
      // FIFO runs dry after two words
      add(3, 0, 1, 1, 0, 0, 4'h0); add(0, 0, 1, 1, 0, 0, 4'h0);
      add(0, 0, 1, 0, 1, 1, 4'h9); add(0, 0, 1, 0, 1, 1, 4'hB);
      add(0, 0, 1, 0, 0, 0, 4'h0); add(0, 0, 1, 0, 0, 0, 4'h0);
      // reset with one word buffered and one in flight, then new FIFO contents
      add(4, 0, 0, 1, 0, 0, 4'h0); add(0, 0, 0, 1, 0, 0, 4'h0);
      add(0, 1, 0, 0, 1, 1, 4'hD);
      add(5, 0, 1, 1, 0, 1, 4'h0); add(0, 0, 1, 1, 0, 0, 4'h0);
      add(0, 0, 1, 0, 1, 1, 4'h6); add(0, 0, 1, 0, 1, 1, 4'h3);
      add(0, 0, 1, 0, 0, 0, 4'h0);
      foreach (tbl[i]) begin
         if (tbl[i].ld != 0) load(tbl[i].ld);
         cyc(tbl[i].rst, tbl[i].rdy, o_ren, o_vld, o_d);
         chk($sformatf("vec%0d_ren", i), {15'd0, o_ren}, {15'd0, tbl[i].ren});
         chk($sformatf("vec%0d_valid", i), {15'd0, o_vld}, {15'd0, tbl[i].vld});
         if (tbl[i].chkd) chk($sformatf("vec%0d_data", i), {12'd0, o_d}, {12'd0, tbl[i].d});
      end
`ifdef FIFO_RD_CNT_EN
      cyc(1, 1, o_ren, o_vld, o_d);
      load(6);
      for (int i = 0; i < 9; i++) cyc(0, 1, o_ren, o_vld, o_d);
      chk("cnt_after_5_pops", rd_count, 16'd5);
      cyc(1, 1, o_ren, o_vld, o_d);
      chk("cnt_after_reset", rd_count, 16'd0);
`endif
      // randomized traffic with occasional resets and FIFO starvation
      p_vld = 1'b0; p_rdy = 1'b1; p_rst = 1'b1; p_d = '0;
      for (int i = 0; i < 800; i++) begin
         logic rst, rdy;
         if (fq.size() < 2 && ($urandom % 8) != 0)
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) fq.push_back(4'($urandom));
         rst = (($urandom % 90) == 0);
         rdy = (($urandom % 3) != 0);
         cyc(rst, rdy, o_ren, o_vld, o_d);
         if (p_vld && !p_rdy && !p_rst && o_vld) chk("stall_hold", {12'd0, o_d}, {12'd0, p_d});
         p_vld = o_vld; p_rdy = rdy; p_rst = rst; p_d = o_d;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
